// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with per-slot blanking.
// Digits are latched once per frame; anode and segment lines are registered, active-low.
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] blank_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic [1:0] sel,
  output logic       frame_tick
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [1:0]      sel_next;
  logic [3:0]      shadow [4];
  logic            capture;
  logic            frame_tick_next;
  logic [3:0]      an_next;
  logic [6:0]      seg_next;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_next      = IDLE;
    cnt_next        = '0;
    sel_next        = '0;
    capture         = 1'b0;
    frame_tick_next = 1'b0;
    if (en) begin
      if (state == IDLE) begin
        capture         = 1'b1;
        frame_tick_next = 1'b1;
      end else if (cnt == CW'(SLOT_CYCLES - 1)) begin
        sel_next = sel + 2'd1;
        if (sel == 2'd3) begin
          capture         = 1'b1;
          frame_tick_next = 1'b1;
        end
      end else begin
        cnt_next = cnt + 1'b1;
        sel_next = sel;
      end
      state_next = (cnt_next < CW'(BLANK_CYCLES)) ? BLANK : SHOW;
    end
  end

  // Outputs are computed from next state so they leave the register in step with it;
  // a capture always lands on cnt=0 (BLANK), so the old shadow is never shown.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    if (state_next == SHOW) begin
      seg_next = hex_decode(shadow[sel_next]);
      if (!blank_mask[sel_next]) an_next = ~(4'b0001 << sel_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      frame_tick <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sel        <= sel_next;
      frame_tick <= frame_tick_next;
      an         <= an_next;
      seg        <= seg_next;
      if (capture) begin
        shadow[0] <= d0;
        shadow[1] <= d1;
        shadow[2] <= d2;
        shadow[3] <= d3;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus randomized traffic against a
// time-indexed reference model (slot/digit derived from cycles since enable).
module tb_seg_scan_ctrl;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0] blank_mask = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic [1:0] sel;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;

  seg_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .blank_mask(blank_mask),
    .an(an), .seg(seg), .sel(sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: running flag, cycles since the enabling edge, frame digits.
  logic [6:0] hex_tab [16];
  bit         running = 1'b0;
  int         t = 0;
  logic [3:0] fd [4];
  logic [3:0] mask_s = '0;

  // Anode overlap / gap tracker.
  logic [3:0] prev_an = 4'b1111;
  int         ones_run = 0;
  bit         seen_active = 1'b0;

  function automatic int m_cnt();
    return t % SLOT;
  endfunction

  function automatic int m_sel();
    return (t / SLOT) % 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic capture_frame();
    fd[0] = d0; fd[1] = d1; fd[2] = d2; fd[3] = d3;
  endtask

  task automatic model_edge();
    mask_s = blank_mask;
    if (!en) begin
      running = 1'b0;
    end else if (!running) begin
      running = 1'b1;
      t = 0;
      capture_frame();
    end else begin
      t++;
      if (t % FRAME == 0) capture_frame();
    end
  endtask

  task automatic check_cycle();
    logic [3:0] exp_an, one;
    logic [6:0] exp_seg;
    logic [1:0] exp_sel;
    logic       exp_tick;
    int c, s;
    exp_an = 4'b1111; exp_seg = 7'b1111111; exp_sel = 2'd0; exp_tick = 1'b0;
    if (running) begin
      c = m_cnt();
      s = m_sel();
      exp_sel  = 2'(s);
      exp_tick = (t % FRAME == 0);
      if (c >= BLANK) begin
        exp_seg = hex_tab[fd[s]];
        one     = 4'b0001 << s;
        if (!mask_s[s]) exp_an = ~one;
      end
    end
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("sel", 32'(sel), 32'(exp_sel));
    chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
    chk("an_at_most_one_low", 32'($countones(~an) <= 1), 32'd1);
    if (an != 4'b1111 && an != prev_an) begin
      chk("anode_gap", 32'(prev_an == 4'b1111 && (!seen_active || ones_run >= BLANK)), 32'd1);
    end
    if (an == 4'b1111) ones_run++;
    else begin
      ones_run = 0;
      seen_active = 1'b1;
    end
    prev_an = an;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reset state, asserted asynchronously before the first edge.
    #2 rst = 1'b1;
    #1 check_dark("reset_async");
    @(posedge clk); #1;
    check_dark("reset_held");
    #3 rst = 1'b0;

    // Basic scan of 0,1,2,3; tick on the first cycle, then two full frames.
    d0 = 4'h0; d1 = 4'h1; d2 = 4'h2; d3 = 4'h3; blank_mask = 4'b0000;
    en = 1'b1;
    step();
    chk("first_tick", 32'(frame_tick), 32'd1);
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Change d2 while digit 1 is showing: visible only next frame.
    for (int i = 0; i < 64 && !(m_sel() == 1 && m_cnt() >= BLANK); i++) step();
    chk("reach_digit1_show", 32'(m_sel() == 1 && m_cnt() >= BLANK), 32'd1);
    d2 = 4'hF;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Mask digit 2 for two frames (changed at a slot boundary).
    for (int i = 0; i < 64 && m_cnt() != SLOT - 1; i++) step();
    blank_mask = 4'b0100;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      chk("masked_anode_absent", 32'(an != 4'b1011), 32'd1);
    end
    for (int i = 0; i < 64 && m_cnt() != SLOT - 1; i++) step();
    blank_mask = 4'b0000;

    // Drop en during digit 2 SHOW, then re-enable.
    for (int i = 0; i < 64 && !(m_sel() == 2 && m_cnt() >= BLANK); i++) step();
    chk("reach_digit2_show", 32'(m_sel() == 2 && m_cnt() >= BLANK), 32'd1);
    en = 1'b0;
    step();
    check_dark("en_drop");
    step();
    en = 1'b1;
    step();
    chk("reenable_tick", 32'(frame_tick), 32'd1);
    for (int i = 0; i < FRAME + 4; i++) step();

    // Asynchronous reset in the middle of digit 1's SHOW phase.
    for (int i = 0; i < 64 && !(m_sel() == 1 && m_cnt() >= BLANK + 1); i++) step();
    chk("reach_reset_point", 32'(an == 4'b1101), 32'd1);
    #2 rst = 1'b1;
    #1 check_dark("rst_mid_slot");
    running = 1'b0;
    @(posedge clk); #1;
    check_dark("rst_mid_slot_held");
    #3 rst = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) step();

    // Randomized traffic: digits change every cycle, occasional en drops,
    // mask changes only at slot boundaries.
    for (int i = 0; i < 1500; i++) begin
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      if (running && m_cnt() == SLOT - 1) blank_mask = 4'($urandom);
      en = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
